// File: rtl/memory_pixel_unpacker_if.sv
// Word-in / pixel-out stream bundle for memory_pixel_unpacker.
// master drives MEM_OUT/MEM_VALID/PIX_READY; slave drives the rest.
interface memory_pixel_unpacker_if #(
  parameter int PIXELS_PER_WORD = 2
);
  logic [8*PIXELS_PER_WORD-1:0] MEM_OUT;
  logic                         MEM_VALID;
  logic                         MEM_READY;
  logic [23:0]                  PIX_RGB;
  logic                         PIX_VALID;
  logic                         PIX_READY;
  logic                         PIX_LAST;

  modport master (
    output MEM_OUT,
    output MEM_VALID,
    output PIX_READY,
    input  MEM_READY,
    input  PIX_RGB,
    input  PIX_VALID,
    input  PIX_LAST
  );

  modport slave (
    input  MEM_OUT,
    input  MEM_VALID,
    input  PIX_READY,
    output MEM_READY,
    output PIX_RGB,
    output PIX_VALID,
    output PIX_LAST
  );
endinterface

// File: rtl/memory_pixel_unpacker.sv
// Unpacks memory words of 8-bit pixel codes into a stream of 24-bit RGB
// pixels. Ports: CLK, RST (sync, active-high), bus (slave side of the if).
module pixel_decoder (
  input  logic [7:0]  code,
  output logic [23:0] rgb
);
  // RGB332 code expanded to 8 bits per channel by bit replication
  logic [2:0] r3;
  logic [2:0] g3;
  logic [1:0] b2;

  always_comb begin
    r3  = code[7:5];
    g3  = code[4:2];
    b2  = code[1:0];
    rgb = {r3, r3, r3[2:1],
           g3, g3, g3[2:1],
           b2, b2, b2, b2};
  end
endmodule

module memory_pixel_unpacker #(
  parameter int PIXELS_PER_WORD = 2,
  parameter bit MSB_FIRST       = 1'b1
) (
  input logic                     CLK,
  input logic                     RST,
  memory_pixel_unpacker_if.slave  bus
);
  localparam int P  = PIXELS_PER_WORD;
  localparam int IW = (P > 1) ? $clog2(P) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(P - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  state_e          state_q, state_d;
  logic [8*P-1:0]  word_q, word_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [23:0]     rgb_q, rgb_d;
  logic            valid_q, valid_d;

  logic            at_last;
  logic            pix_xfer;
  logic            mem_ready;
  logic            word_xfer;
  logic [IW-1:0]   nxt_idx;
  logic [7:0]      code_sel;
  logic [23:0]     dec_rgb;

  function automatic logic [7:0] pick(
    input logic [8*P-1:0] w,
    input logic [IW-1:0]  k
  );
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < P; i++) begin
      if (k == IW'(i)) begin
        c = MSB_FIRST ? w[8*(P-1-i) +: 8]
                      : w[8*i +: 8];
      end
    end
    return c;
  endfunction

  assign at_last  = (idx_q == LAST_IDX);
  assign pix_xfer = valid_q && bus.PIX_READY;

  // Ready is combinational from PIX_READY on the last pixel so a new
  // word can replace the old one without a bubble.
  assign mem_ready = !RST &&
    ((state_q == IDLE) ||
     ((state_q == STREAM) && at_last && bus.PIX_READY));

  assign word_xfer = bus.MEM_VALID && mem_ready;
  assign nxt_idx   = at_last ? '0 : idx_q + 1'b1;

  // Single decoder: either pixel 0 of the incoming word or the next
  // pixel of the held word.
  assign code_sel = word_xfer ? pick(bus.MEM_OUT, '0)
                              : pick(word_q, nxt_idx);

  pixel_decoder u_dec (
    .code (code_sel),
    .rgb  (dec_rgb)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    rgb_d   = rgb_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (word_xfer) begin
          word_d  = bus.MEM_OUT;
          idx_d   = '0;
          rgb_d   = dec_rgb;
          valid_d = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (pix_xfer) begin
          if (!at_last) begin
            idx_d = nxt_idx;
            rgb_d = dec_rgb;
          end else if (word_xfer) begin
            word_d  = bus.MEM_OUT;
            idx_d   = '0;
            rgb_d   = dec_rgb;
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      rgb_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      rgb_q   <= rgb_d;
      valid_q <= valid_d;
    end
  end

  assign bus.MEM_READY = mem_ready;
  assign bus.PIX_RGB   = rgb_q;
  assign bus.PIX_VALID = valid_q;
  assign bus.PIX_LAST  = valid_q && at_last;
endmodule

// File: doc/memory_pixel_unpacker.md
MEMORY_PIXEL_UNPACKER -- requirements
Module: memory_pixel_unpacker

Interface
REQ-001 Parameter PIXELS_PER_WORD, default 2, number of 8-bit pixel codes packed in one memory word (legal range 1..8).
REQ-002 Parameter MSB_FIRST, default 1, pixel order within a word: 1 = pixel 0 is the most significant byte; 0 = pixel 0 is the least significant byte.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 CLK  input  1  system clock; all state changes on the rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 MEM_OUT  input  8*PIXELS_PER_WORD  packed pixel-code word from memory.
REQ-007 MEM_VALID  input  1  MEM_OUT holds a valid word.
REQ-008 MEM_READY  output  1  block accepts MEM_OUT this cycle; a word transfers when MEM_VALID and MEM_READY are both 1.
REQ-009 PIX_RGB  output  24  decoded RGB of the current pixel.
REQ-010 PIX_VALID  output  1  PIX_RGB holds a valid pixel.
REQ-011 PIX_READY  input  1  downstream accepts the pixel; a pixel transfers when PIX_VALID and PIX_READY are both 1.
REQ-012 PIX_LAST  output  1  the current pixel is the last pixel of its word.

Function
REQ-013 Code to RGB conversion SHALL use exactly one pixel_decoder instance, fed by a multiplexer that selects the code for the pixel being loaded.
REQ-014 Internal state: word register WORD, index register IDX of width clog2(PIXELS_PER_WORD) (minimum 1 bit), and FSM states IDLE and STREAM.
REQ-015 MEM_READY SHALL be 1 when the FSM is in IDLE.
REQ-016 MEM_READY SHALL also be 1 in STREAM when IDX = PIXELS_PER_WORD-1 and PIX_READY = 1; in that case MEM_READY is combinational from PIX_READY.
REQ-017 MEM_READY SHALL be 0 in all other cases, including every cycle in which RST = 1.
REQ-018 In IDLE, on a word transfer: WORD <= MEM_OUT, IDX <= 0, PIX_RGB <= decode(pixel 0 of MEM_OUT), PIX_VALID <= 1, next state STREAM.
REQ-019 First-pixel latency: PIX_VALID SHALL rise on the clock edge that accepts the word, so the pixel is visible in the next cycle.
REQ-020 In STREAM, when PIX_VALID = 1 and PIX_READY = 0, PIX_RGB, PIX_LAST, IDX and WORD SHALL hold their values.
REQ-021 In STREAM, on a pixel transfer with IDX < PIXELS_PER_WORD-1: IDX <= IDX+1 and PIX_RGB <= decode(pixel IDX+1 of WORD); PIX_VALID stays 1.
REQ-022 In STREAM, on a pixel transfer with IDX = PIXELS_PER_WORD-1 and MEM_VALID = 1: load the new word exactly as in REQ-018 and stay in STREAM, giving back-to-back words with no bubble.
REQ-023 In STREAM, on a pixel transfer with IDX = PIXELS_PER_WORD-1 and MEM_VALID = 0: PIX_VALID <= 0, next state IDLE; PIX_RGB keeps its last value.
REQ-024 PIX_LAST SHALL equal PIX_VALID AND (IDX = PIXELS_PER_WORD-1).
REQ-025 With PIXELS_PER_WORD = 1, IDX SHALL remain 0, PIX_LAST SHALL equal PIX_VALID, and every pixel transfer SHALL be eligible to accept a new word.
REQ-026 Pixel k SHALL be MEM_OUT[8*(P-k)-1 : 8*(P-k-1)] when MSB_FIRST = 1, and MEM_OUT[8*k+7 : 8*k] when MSB_FIRST = 0, where P = PIXELS_PER_WORD.
REQ-027 MEM_OUT SHALL only be sampled on a word transfer; changes to MEM_OUT at any other time SHALL have no effect.
REQ-028 The block SHALL neither drop nor duplicate pixels: each accepted word yields exactly PIXELS_PER_WORD pixel transfers, in order.

Reset
REQ-029 While RST = 1 at a clock edge: state <= IDLE, IDX <= 0, WORD <= 0, PIX_RGB <= 0, PIX_VALID <= 0; consequently PIX_LAST = 0.
REQ-030 Reset asserted mid-word SHALL discard the remaining pixels of that word; the first cycle after RST falls SHALL show MEM_READY = 1 and PIX_VALID = 0.
REQ-031 A word presented with MEM_VALID = 1 during a cycle with RST = 1 SHALL NOT be accepted.

Verification
REQ-032 Defaults, MEM_OUT = 16'hA15C held valid for 1 cycle, PIX_READY = 1 -> next cycle PIX_RGB = decode(8'hA1) with PIX_LAST = 0; the cycle after, PIX_RGB = decode(8'h5C) with PIX_LAST = 1; then PIX_VALID = 0 and MEM_READY = 1.
REQ-033 Defaults, words 16'h0102 then 16'h0304 offered back-to-back, PIX_READY = 1 -> four consecutive valid pixels decoding codes 01, 02, 03, 04 with no idle cycle; MEM_READY = 1 during the cycle the code-02 pixel is shown.
REQ-034 Backpressure: hold PIX_READY = 0 for 5 cycles while the code-01 pixel is shown -> PIX_RGB is stable, MEM_READY = 0, and no new word is accepted.
REQ-035 PIXELS_PER_WORD = 4, MSB_FIRST = 0, MEM_OUT = 32'h44332211 -> pixels decode codes 11, 22, 33, 44 in that order; PIX_LAST = 1 only on code 44.
REQ-036 RST pulsed for 1 cycle while the second pixel of a word is pending -> the following cycle shows PIX_VALID = 0, PIX_RGB = 0, MEM_READY = 1, and the next accepted word starts at pixel 0.
REQ-037 Random MEM_VALID and PIX_READY over 10000 cycles, checked against a pixel_decoder-based scoreboard -> zero mismatches, zero lost pixels and zero duplicated pixels.
